// File: rtl/hiscore_ram_bridge_pkg.sv
// Shared types and helpers for the hiscore RAM bridge.
package taitosj_hs_pkg;

  typedef enum logic [1:0] {CPU, SETUP, ACTIVE, RELEASE} hs_state_t;

  localparam logic [7:0] HS_OOW_DATA = 8'hFF;

  // 17-bit compare so the top of the address space cannot wrap into the window
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int unsigned aw);
    logic [16:0] diff;
    diff = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (diff < (17'd1 << aw));
  endfunction

endpackage

// File: rtl/hiscore_ram_bridge_guard.sv
// Handover guard: loads a cycle count and flags the last cycle of the interval.
module hs_guard_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == WIDTH'(1));

endmodule

// File: rtl/hiscore_ram_bridge.sv
// Arbitrates one work-RAM port between the CPU and the hiscore engine while
// the CPU is paused; serves hiscore reads and counts dropped hiscore writes.
module hiscore_ram_bridge
  import taitosj_hs_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned GUARD    = 1
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              pause_cpu,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  input  logic              hs_access_read,
  input  logic              hs_access_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_busy,
  output logic [7:0]        hs_dropped,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  hs_state_t         state, state_n;
  logic              intent;
  logic              hs_win, cpu_win;
  logic [RAM_AW-1:0] hs_off, cpu_off;
  logic              guard_load, guard_expire;
  logic              wr_v;
  logic [RAM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              win_d1, act_d1;

  assign intent  = hs_access_read | hs_access_write;
  assign hs_win  = in_window(hs_address, RAM_BASE, RAM_AW);
  assign cpu_win = in_window(cpu_addr, RAM_BASE, RAM_AW);
  assign hs_off  = RAM_AW'(hs_address - RAM_BASE);
  assign cpu_off = RAM_AW'(cpu_addr - RAM_BASE);
  assign hs_busy = (state != CPU);

  hs_guard_counter #(.WIDTH(2)) u_guard (
    .clk      (clk_sys),
    .rst_n    (RESET_n),
    .load     (guard_load),
    .load_val (2'(GUARD)),
    .expire   (guard_expire)
  );

  always_comb begin
    state_n    = state;
    guard_load = 1'b0;
    case (state)
      CPU: if (pause_cpu && intent) begin
        state_n    = SETUP;
        guard_load = 1'b1;
      end
      SETUP: if (!pause_cpu || !intent) begin
        state_n    = RELEASE;
        guard_load = 1'b1;
      end else if (guard_expire) begin
        state_n = ACTIVE;
      end
      ACTIVE: if (!pause_cpu || !intent) begin
        state_n    = RELEASE;
        guard_load = 1'b1;
      end
      RELEASE: if (guard_expire) state_n = CPU;
      default: state_n = CPU;
    endcase
  end

  // A registered hiscore write owns the port for its cycle, including the
  // first RELEASE cycle when it was captured on ACTIVE exit.
  always_comb begin
    ram_addr = hs_off;
    ram_din  = hs_data_in;
    ram_we   = 1'b0;
    if (state == CPU) begin
      ram_addr = cpu_off;
      ram_din  = cpu_dout;
      ram_we   = cpu_wr & cpu_win;
    end else if (wr_v) begin
      ram_addr = wr_addr;
      ram_din  = wr_data;
      ram_we   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= CPU;
      wr_v        <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      win_d1      <= 1'b0;
      act_d1      <= 1'b0;
      hs_data_out <= '0;
      hs_dropped  <= '0;
    end else begin
      state   <= state_n;
      wr_v    <= (state == ACTIVE) && hs_write && hs_win;
      wr_addr <= hs_off;
      wr_data <= hs_data_in;
      win_d1  <= hs_win;
      act_d1  <= (state == ACTIVE);
      if (act_d1 && state == ACTIVE)
        hs_data_out <= win_d1 ? ram_dout : HS_OOW_DATA;
      if (hs_write && state != ACTIVE && hs_dropped != '1)
        hs_dropped <= hs_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_bridge.sv
// Directed bench for hiscore_ram_bridge with a behavioural synchronous RAM.
module tb_hiscore_ram_bridge;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        pause_cpu;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic        hs_access_read;
  logic        hs_access_write;
  logic [7:0]  hs_data_out;
  logic        hs_busy;
  logic [7:0]  hs_dropped;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0] mem [0:2047];
  int unsigned checks = 0;
  int unsigned errors = 0;

  hiscore_ram_bridge #(.RAM_BASE(16'h8000), .RAM_AW(11), .GUARD(1)) dut (
    .clk_sys         (clk_sys),
    .RESET_n         (RESET_n),
    .pause_cpu       (pause_cpu),
    .hs_address      (hs_address),
    .hs_data_in      (hs_data_in),
    .hs_write        (hs_write),
    .hs_access_read  (hs_access_read),
    .hs_access_write (hs_access_write),
    .hs_data_out     (hs_data_out),
    .hs_busy         (hs_busy),
    .hs_dropped      (hs_dropped),
    .cpu_addr        (cpu_addr),
    .cpu_dout        (cpu_dout),
    .cpu_wr          (cpu_wr),
    .ram_addr        (ram_addr),
    .ram_din         (ram_din),
    .ram_we          (ram_we),
    .ram_dout        (ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    RESET_n = 1'b0; pause_cpu = 1'b0; hs_address = '0; hs_data_in = '0;
    hs_write = 1'b0; hs_access_read = 1'b0; hs_access_write = 1'b0;
    cpu_addr = '0; cpu_dout = '0; cpu_wr = 1'b0;
    #12;
    check("rst_busy", 16'(hs_busy), 16'h0);
    check("rst_dout", 16'(hs_data_out), 16'h00);
    check("rst_drop", 16'(hs_dropped), 16'h00);
    check("rst_we", 16'(ram_we), 16'h0);
    @(negedge clk_sys);
    RESET_n = 1'b1;

    // CPU pass-through
    tick(); cpu_wr = 1'b1; cpu_addr = 16'h8010; cpu_dout = 8'h5A; #1;
    check("cpu_we", 16'(ram_we), 16'h1);
    check("cpu_addr", 16'(ram_addr), 16'h010);
    check("cpu_din", 16'(ram_din), 16'h5A);
    check("cpu_busy", 16'(hs_busy), 16'h0);
    tick(); cpu_addr = 16'h4000; #1;
    check("cpu_oow_we", 16'(ram_we), 16'h0);

    // Handover and hiscore write
    tick(); cpu_wr = 1'b0; pause_cpu = 1'b1; hs_access_write = 1'b1; #1;
    check("cpu_busy2", 16'(hs_busy), 16'h0);
    tick(); #1;
    check("setup_busy", 16'(hs_busy), 16'h1);
    tick(); hs_write = 1'b1; hs_address = 16'h8123; hs_data_in = 8'h3C; #1;
    check("hsw_lat0", 16'(ram_we), 16'h0);
    tick(); hs_write = 1'b0; #1;
    check("hsw_we", 16'(ram_we), 16'h1);
    check("hsw_addr", 16'(ram_addr), 16'h123);
    check("hsw_din", 16'(ram_din), 16'h3C);
    check("hsw_drop", 16'(hs_dropped), 16'h00);

    // Reads with two-cycle latency
    tick(); hs_access_read = 1'b1; hs_address = 16'h8010;
    tick(); hs_address = 16'h8123;
    tick(); hs_address = 16'h4000; #1;
    check("rd_8010", 16'(hs_data_out), 16'h5A);
    tick(); hs_address = 16'h87FF; #1;
    check("rd_8123", 16'(hs_data_out), 16'h3C);
    tick(); hs_address = 16'h8800; #1;
    check("rd_4000", 16'(hs_data_out), 16'hFF);
    tick(); #1;
    check("rd_87ff", 16'(hs_data_out), 16'h00);
    tick(); #1;
    check("rd_8800", 16'(hs_data_out), 16'hFF);

    // Out-of-window write in ACTIVE: ignored, not counted
    tick(); hs_write = 1'b1; hs_address = 16'h4000; hs_data_in = 8'h99;
    tick(); hs_write = 1'b0; #1;
    check("oow_we", 16'(ram_we), 16'h0);
    check("oow_drop", 16'(hs_dropped), 16'h00);

    // Exit coincident with a write; cpu_wr blocked during RELEASE
    tick(); hs_write = 1'b1; hs_address = 16'h8200; hs_data_in = 8'hA5; pause_cpu = 1'b0;
    tick(); hs_write = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h8300; cpu_dout = 8'h77; #1;
    check("exit_we", 16'(ram_we), 16'h1);
    check("exit_addr", 16'(ram_addr), 16'h200);
    check("exit_din", 16'(ram_din), 16'hA5);
    check("rel_busy", 16'(hs_busy), 16'h1);
    tick(); #1;
    check("back_busy", 16'(hs_busy), 16'h0);
    check("back_we", 16'(ram_we), 16'h1);
    check("back_addr", 16'(ram_addr), 16'h300);
    check("exit_drop", 16'(hs_dropped), 16'h00);

    // Dropped-write saturation
    tick(); cpu_wr = 1'b0; hs_access_write = 1'b0; hs_access_read = 1'b0;
    hs_write = 1'b1; hs_address = 16'h8020; #1;
    check("drop_we", 16'(ram_we), 16'h0);
    tick(); #1;
    check("drop_1", 16'(hs_dropped), 16'h01);
    repeat (253) tick();
    check("drop_fe", 16'(hs_dropped), 16'hFE);
    repeat (47) tick();
    check("drop_sat", 16'(hs_dropped), 16'hFF);
    check("drop_busy", 16'(hs_busy), 16'h0);

    // Reset mid-ACTIVE with a pending write
    hs_write = 1'b0; pause_cpu = 1'b1; hs_access_write = 1'b1; hs_address = 16'h8400;
    tick();
    tick(); hs_write = 1'b1; hs_data_in = 8'h11;
    tick(); hs_write = 1'b0; #1;
    check("pre_rst_we", 16'(ram_we), 16'h1);
    check("pre_rst_dout", 16'(hs_data_out), 16'hFF);
    check("pre_rst_drop", 16'(hs_dropped), 16'hFF);
    RESET_n = 1'b0; #1;
    check("mid_rst_we", 16'(ram_we), 16'h0);
    check("mid_rst_busy", 16'(hs_busy), 16'h0);
    check("mid_rst_drop", 16'(hs_dropped), 16'h00);
    check("mid_rst_dout", 16'(hs_data_out), 16'h00);
    tick();
    RESET_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_bridge.md
Name: hiscore_ram_bridge

Overview:
- Game-side responder for the hiscore engine's RAM access interface.
- Sits inside the game core, between the CPU work-RAM bus and one synchronous work-RAM port.
- While the CPU is paused and the hiscore engine signals read/write intent, it hands the RAM port to the hiscore engine; otherwise it passes CPU accesses through unchanged.
- Serves hiscore reads with fixed latency, and counts hiscore writes it had to drop.

Parameters:
- RAM_BASE, 16'h8000, CPU/hiscore address of work-RAM byte 0.
- RAM_AW, 11, work-RAM address width; the window is RAM_BASE .. RAM_BASE+2^RAM_AW-1.
- GUARD, 1, idle cycles inserted on each handover (valid range 1..3).

Ports:
- clk_sys  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- pause_cpu  in  1  CPU halted (from pause block).
- hs_address  in  16  hiscore byte address.
- hs_data_in  in  8  hiscore write data.
- hs_write  in  1  hiscore write strobe, one cycle per byte.
- hs_access_read  in  1  hiscore read intent.
- hs_access_write  in  1  hiscore write intent.
- hs_data_out  out  8  read data returned to the hiscore engine.
- hs_busy  out  1  bridge is not in CPU state.
- hs_dropped  out  8  saturating count of dropped hiscore writes.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_wr  in  1  CPU write strobe.
- ram_addr  out  RAM_AW  RAM port address.
- ram_din  out  8  RAM port write data.
- ram_we  out  1  RAM port write enable.
- ram_dout  in  8  RAM read data, valid 1 cycle after ram_addr.

Behaviour:
- Reset (async, RESET_n=0):
  - state=CPU, hs_data_out=8'h00, hs_busy=0, hs_dropped=0.
  - Registered write stage cleared, so ram_we=0.
- Intent = hs_access_read | hs_access_write.
- States:
  - CPU: RAM mux selects CPU.
    - ram_addr=cpu_addr-RAM_BASE (low RAM_AW bits), ram_din=cpu_dout.
    - ram_we=cpu_wr & in_window(cpu_addr), combinational.
    - Go to SETUP when pause_cpu & intent.
  - SETUP: mux selects hiscore; ram_we forced 0.
    - Counts GUARD cycles, then ACTIVE.
    - If pause_cpu or intent drops during SETUP, go to RELEASE.
  - ACTIVE: mux selects hiscore; ram_addr=hs_address-RAM_BASE.
    - Write stage registers {hs_write & in_window(hs_address), offset, hs_data_in}. ram_we is asserted the cycle after hs_write (latency 1).
    - Go to RELEASE when intent=0 or pause_cpu=0. A write captured in the exit cycle still completes.
  - RELEASE: mux still hiscore, no new writes accepted.
    - Counts GUARD cycles, then CPU.
- hs_busy=1 in SETUP, ACTIVE and RELEASE.
- Reads:
  - Pipeline (address stable at cycle N → ram_dout at N+1 → register): hs_data_out is updated at N+2 with ram_dout when in_window delayed 2 cycles is set, else 8'hFF.
  - hs_data_out updates only while in ACTIVE; it holds its value in all other states.
- Dropped writes:
  - An hs_write seen in CPU, SETUP or RELEASE is ignored and increments hs_dropped.
  - An out-of-window hs_write in ACTIVE is ignored and does not count.
  - hs_dropped saturates at 8'hFF.
- Simultaneous events:
  - cpu_wr is never forwarded outside CPU state.
  - hs_write and an exit condition in the same cycle: the write is accepted.
- Window test: in_window(a) = a >= RAM_BASE and a - RAM_BASE < 2^RAM_AW, computed in 17-bit arithmetic; the top address 16'hFFFF does not wrap.
- Reset mid-operation returns to CPU immediately; any pending write is discarded.

Decomposition:
- Shared package taitosj_hs_pkg holds:
  - state enum {CPU, SETUP, ACTIVE, RELEASE};
  - HS_OOW_DATA=8'hFF;
  - function in_window(addr, base, aw).
- One natural sub-module, hs_guard_counter: a small down-counter, load/expire, reused by SETUP and RELEASE.
- Everything else is flat.

Test Plan:
1. Unpaused, cpu_wr=1, cpu_addr=16'h8010, cpu_dout=8'h5A → same cycle ram_we=1, ram_addr=11'h010; hs_busy stays 0.
2. pause_cpu=1, hs_access_write=1, then hs_write pulse at 16'h8123 with data 8'h3C → hs_busy rises; after GUARD=1 the bridge is in ACTIVE; ram_we=1, ram_addr=11'h123, ram_din=8'h3C one cycle after the strobe.
3. In ACTIVE with a read at 16'h8123 (RAM model holds 8'h3C) → hs_data_out=8'h3C exactly 2 cycles after the address; read at 16'h4000 → 8'hFF.
4. hs_write while unpaused, then 300 further unpaused writes → no ram_we; hs_dropped counts to 8'hFF and saturates.
5. In ACTIVE, pause_cpu drops in the same cycle as hs_write → the write is performed; RELEASE lasts GUARD cycles, then CPU; a cpu_wr during RELEASE is not forwarded.
6. RESET_n pulsed low mid-ACTIVE with a write pending → ram_we=0 immediately, state CPU, hs_dropped=0, hs_data_out=8'h00.
